rx_word_axis_framer: RTL and testbench

Downstream of the receive byte-to-word/FCS-insert stage. Consumes its 64-bit word strobes and the packet's byte count, and frames each packet onto a 64-bit AXI-Stream master with per-beat `tkeep` and a `tlast` on the final beat. An internal FIFO absorbs DMA backpressure. Admission is all-or-nothing per packet, so the stream never carries a partial packet caused by overflow.

---
 rtl/rx_intf_pkg.sv | 27 ++
 rtl/sync_fifo_fwft.sv | 70 +++++++
 rtl/rx_word_axis_framer.sv | 183 ++++++++++++++++++
 tb/tb_rx_word_axis_framer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_intf_pkg.sv
// rx_intf_pkg
// Shared definitions for the receive framing path:
//   - state_t        : framer states (IDLE / ACCEPT / DROP)
//   - DATA_W/KEEP_W  : beat payload and byte-enable widths
//   - ENTRY_W        : FIFO entry width, {last, keep[7:0], data[63:0]} = 73 bits
//   - keep_from_len  : byte enables of the final beat from the low 3 length bits
package rx_intf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    DROP   = 2'd2
  } state_t;

  localparam int DATA_W  = 64;
  localparam int KEEP_W  = 8;
  localparam int ENTRY_W = DATA_W + KEEP_W + 1;

  // A length that is a multiple of 8 fills the last beat completely.
  function automatic logic [KEEP_W-1:0] keep_from_len(input logic [2:0] rem);
    if (rem == 3'd0) begin
      return 8'hFF;
    end
    return (8'h01 << rem) - 8'h01;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
// Synchronous first-word-fall-through FIFO with a registered output stage.
// Ports:
//   clk, rstn          : clock, synchronous active-low reset
//   wr_en, wr_data     : push one entry
//   rd_en              : consume the presented entry (only effective with rd_valid)
//   rd_data, rd_valid  : head entry, held stable until consumed
//   level              : entries stored (memory plus output register)
// The memory holds DEPTH entries; callers must never push when level == DEPTH.
module sync_fifo_fwft #(
  parameter int WIDTH = 73,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [AW:0]      level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      mem_cnt;
  logic             pop;
  logic             load;

  assign pop  = rd_valid && rd_en;
  // Refill the output register whenever it is empty or being consumed.
  assign load = (mem_cnt != '0) && (!rd_valid || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      level    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_data  <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
      mem_cnt <= mem_cnt + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, load};
      level   <= level + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
      // Admission reserves space for whole packets, so a full FIFO is never written.
      assert (!(wr_en && level == FULL_LEVEL));
    end
  end

endmodule

// File: rtl/rx_word_axis_framer.sv
// rx_word_axis_framer
// Frames 64-bit receive words into packets on an AXI-Stream master, with an
// internal FIFO absorbing sink backpressure. Packets are admitted whole or
// dropped whole at pkt_start, so overflow never leaves a partial packet.
// Ports:
//   clk, rstn                    : clock, synchronous active-low reset
//   pkt_start, num_byte          : packet open pulse and its byte length
//   word_in, word_in_strobe      : little-endian payload word and its valid
//   m_axis_t{data,keep,last,valid,ready} : AXI-Stream master
//   pkt_drop                     : pulse, packet rejected at admission
//   pkt_trunc                    : pulse, packet closed early by a new pkt_start
//   word_err                     : pulse, word strobe discarded
//   fifo_level                   : words currently stored in the FIFO
module rx_word_axis_framer
  import rx_intf_pkg::*;
#(
  parameter int FIFO_AW = 9
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                pkt_start,
  input  logic [15:0]         num_byte,
  input  logic [DATA_W-1:0]   word_in,
  input  logic                word_in_strobe,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [KEEP_W-1:0]   m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                pkt_drop,
  output logic                pkt_trunc,
  output logic                word_err,
  output logic [FIFO_AW:0]    fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;

  state_t              state, state_next;
  logic [16:0]         len_plus7;
  logic [13:0]         exp_words;
  logic [13:0]         exp_words_q, exp_words_next;
  logic [13:0]         rcvd, rcvd_next;
  logic [KEEP_W-1:0]   keep_q, keep_next;
  logic [DATA_W-1:0]   held_data, held_data_next;
  logic                held_valid, held_valid_next;
  logic                held_last, held_last_next;
  logic                push;
  logic [ENTRY_W-1:0]  push_entry;
  logic [16:0]         need;
  logic                drop_set, trunc_set, err_set;
  logic [ENTRY_W-1:0]  rd_entry;

  assign len_plus7 = {1'b0, num_byte} + 17'd7;
  assign exp_words = len_plus7[16:3];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      exp_words_q <= '0;
      rcvd        <= '0;
      keep_q      <= '0;
      held_data   <= '0;
      held_valid  <= 1'b0;
      held_last   <= 1'b0;
      pkt_drop    <= 1'b0;
      pkt_trunc   <= 1'b0;
      word_err    <= 1'b0;
    end else begin
      state       <= state_next;
      exp_words_q <= exp_words_next;
      rcvd        <= rcvd_next;
      keep_q      <= keep_next;
      held_data   <= held_data_next;
      held_valid  <= held_valid_next;
      held_last   <= held_last_next;
      pkt_drop    <= drop_set;
      pkt_trunc   <= trunc_set;
      word_err    <= err_set;
    end
  end

  // When the final word arrives while an earlier word is still held, the FIFO
  // would need two writes in one cycle. Instead the held word is pushed and the
  // final word is parked (held_last) and pushed on the following idle cycle.
  always_comb begin
    state_next      = state;
    exp_words_next  = exp_words_q;
    rcvd_next       = rcvd;
    keep_next       = keep_q;
    held_data_next  = held_data;
    held_valid_next = held_valid;
    held_last_next  = held_last;
    push            = 1'b0;
    push_entry      = '0;
    need            = '0;
    drop_set        = 1'b0;
    trunc_set       = 1'b0;
    err_set         = 1'b0;

    if (held_valid && held_last) begin
      push            = 1'b1;
      push_entry      = {1'b1, keep_q, held_data};
      held_valid_next = 1'b0;
      held_last_next  = 1'b0;
    end

    unique case (state)
      ACCEPT: begin
        if (pkt_start) begin
          if (held_valid) begin
            push            = 1'b1;
            push_entry      = {1'b1, 8'hFF, held_data};
            held_valid_next = 1'b0;
            trunc_set       = 1'b1;
          end
        end else if (word_in_strobe) begin
          rcvd_next = rcvd + 14'd1;
          if (rcvd_next == exp_words_q) begin
            state_next = IDLE;
            if (held_valid) begin
              push           = 1'b1;
              push_entry     = {1'b0, 8'hFF, held_data};
              held_data_next = word_in;
              held_last_next = 1'b1;
            end else begin
              push       = 1'b1;
              push_entry = {1'b1, keep_q, word_in};
            end
          end else begin
            if (held_valid) begin
              push       = 1'b1;
              push_entry = {1'b0, 8'hFF, held_data};
            end
            held_data_next  = word_in;
            held_valid_next = 1'b1;
          end
        end
      end
      IDLE: begin
        if (word_in_strobe && !pkt_start) begin
          err_set = 1'b1;
        end
      end
      default: ;
    endcase

    // Admission counts any word being pushed this cycle as already stored.
    if (pkt_start) begin
      if (word_in_strobe) begin
        err_set = 1'b1;
      end
      need = 17'(exp_words) + 17'(fifo_level) + 17'(push);
      if (num_byte == 16'd0 || need > 17'(DEPTH)) begin
        drop_set   = 1'b1;
        state_next = DROP;
      end else begin
        state_next     = ACCEPT;
        rcvd_next      = '0;
        exp_words_next = exp_words;
        keep_next      = keep_from_len(num_byte[2:0]);
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (push),
    .wr_data  (push_entry),
    .rd_en    (m_axis_tready),
    .rd_data  (rd_entry),
    .rd_valid (m_axis_tvalid),
    .level    (fifo_level)
  );

  assign m_axis_tdata = rd_entry[DATA_W-1:0];
  assign m_axis_tkeep = rd_entry[DATA_W +: KEEP_W];
  assign m_axis_tlast = rd_entry[ENTRY_W-1];

endmodule

// File: tb/tb_rx_word_axis_framer.sv
// tb_rx_word_axis_framer
// Scoreboard bench: stimulus tasks queue the expected beats as words are
// issued, and a negedge monitor pops and compares every accepted beat. The
// monitor also checks that a stalled beat is held stable and counts pulses.
module tb_rx_word_axis_framer;

  localparam int AW = 9;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pkt_start = 1'b0;
  logic [15:0] num_byte = '0;
  logic [63:0] word_in = '0;
  logic        word_in_strobe = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        pkt_drop;
  logic        pkt_trunc;
  logic        word_err;
  logic [AW:0] fifo_level;

  rx_word_axis_framer #(.FIFO_AW(AW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .pkt_start      (pkt_start),
    .num_byte       (num_byte),
    .word_in        (word_in),
    .word_in_strobe (word_in_strobe),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .pkt_drop       (pkt_drop),
    .pkt_trunc      (pkt_trunc),
    .word_err       (word_err),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          drop_seen = 0;
  int          trunc_seen = 0;
  int          err_seen = 0;
  beat_t       exp_q[$];
  bit          rand_ready_en = 1'b0;
  logic        ready_fixed = 1'b0;
  bit          stall_prev = 1'b0;
  logic [72:0] stall_snap = '0;
  beat_t       mon_beat;

  // Sink ready: fixed level or random toggling.
  always @(posedge clk) begin
    #2;
    m_axis_tready = rand_ready_en ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] lastKeep(input int nbytes);
    logic [2:0] r;
    r = 3'(nbytes);
    return (r == 3'd0) ? 8'hFF : (8'hFF >> (4'd8 - 4'(r)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Opens a packet, sends nstrobes words, then leaves two idle cycles.
  task automatic applyStimulus(input int nbytes, input int nstrobes, input bit expect_beats,
                               input bit coincide, input bit gaps);
    int          nw;
    int          sent;
    beat_t       b;
    logic [63:0] w;
    nw   = (nbytes + 7) / 8;
    sent = (nstrobes < nw) ? nstrobes : nw;
    num_byte  = 16'(nbytes);
    pkt_start = 1'b1;
    if (coincide) begin
      word_in        = 64'hDEAD_BEEF_0BAD_F00D;
      word_in_strobe = 1'b1;
    end
    tick();
    pkt_start      = 1'b0;
    word_in_strobe = 1'b0;
    for (int i = 0; i < nstrobes; i++) begin
      w = {$urandom(), $urandom()};
      word_in        = w;
      word_in_strobe = 1'b1;
      if (expect_beats && i < sent) begin
        b.data = w;
        b.keep = (i == nw - 1) ? lastKeep(nbytes) : 8'hFF;
        b.last = (i == sent - 1);
        exp_q.push_back(b);
      end
      tick();
      word_in_strobe = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) tick();
    end
    tick();
    tick();
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  // Monitor: compare accepted beats, verify stall stability, count pulses.
  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (pkt_drop)  drop_seen++;
      if (pkt_trunc) trunc_seen++;
      if (word_err)  err_seen++;
      if (stall_prev) begin
        checkOutput("stall_hold",
                    128'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
                    128'({1'b1, stall_snap}));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got data %0h keep %0h last %0b, required no beat",
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end else begin
          mon_beat = exp_q.pop_front();
          checkOutput("beat",
                      128'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
                      128'({mon_beat.last, mon_beat.keep, mon_beat.data}));
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_snap = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    end
  end

  initial begin
    logic [63:0] w;
    beat_t       b;
    int          n;

    repeat (3) tick();
    checkOutput("reset_outputs",
                128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
                      pkt_drop, pkt_trunc, word_err, fifo_level}), 128'(0));
    rstn = 1'b1;
    tick();
    checkOutput("post_reset_idle",
                128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
                      pkt_drop, pkt_trunc, word_err, fifo_level}), 128'(0));
    ready_fixed = 1'b1;
    tick();

    $display("[TB] basic packets");
    applyStimulus(20, 3, 1'b1, 1'b0, 1'b0);
    waitDrain(100);
    applyStimulus(16, 2, 1'b1, 1'b0, 1'b0);
    waitDrain(100);

    $display("[TB] single-word latency");
    num_byte  = 16'd5;
    pkt_start = 1'b1;
    tick();
    pkt_start = 1'b0;
    w = {$urandom(), $urandom()};
    b.data = w;
    b.keep = 8'h1F;
    b.last = 1'b1;
    exp_q.push_back(b);
    word_in        = w;
    word_in_strobe = 1'b1;
    tick();
    word_in_strobe = 1'b0;
    checkOutput("latency_n1_tvalid", 128'(m_axis_tvalid), 128'(0));
    tick();
    checkOutput("latency_n2_tvalid", 128'(m_axis_tvalid), 128'(1));
    waitDrain(100);

    $display("[TB] truncation");
    applyStimulus(40, 2, 1'b1, 1'b0, 1'b0);
    applyStimulus(16, 2, 1'b1, 1'b0, 1'b0);
    waitDrain(100);
    checkOutput("trunc_count", 128'(trunc_seen), 128'(1));
    applyStimulus(40, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8, 1, 1'b1, 1'b0, 1'b0);
    waitDrain(100);
    checkOutput("trunc_nothing_held", 128'(trunc_seen), 128'(1));

    $display("[TB] word errors");
    ready_fixed = 1'b0;
    tick();
    applyStimulus(16, 2, 1'b1, 1'b1, 1'b0);
    checkOutput("err_coincide", 128'(err_seen), 128'(1));
    checkOutput("level_after_coincide", 128'(fifo_level), 128'(2));
    word_in        = 64'h0123_4567_89AB_CDEF;
    word_in_strobe = 1'b1;
    tick();
    word_in_strobe = 1'b0;
    tick();
    tick();
    checkOutput("err_idle_strobe", 128'(err_seen), 128'(2));
    checkOutput("level_after_idle_strobe", 128'(fifo_level), 128'(2));
    ready_fixed = 1'b1;
    waitDrain(100);

    $display("[TB] reset mid-packet");
    ready_fixed = 1'b0;
    tick();
    applyStimulus(24, 2, 1'b0, 1'b0, 1'b0);
    checkOutput("midpkt_level", 128'(fifo_level), 128'(1));
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    checkOutput("after_midpkt_reset", 128'({m_axis_tvalid, fifo_level}), 128'(0));
    ready_fixed = 1'b1;
    applyStimulus(8, 1, 1'b1, 1'b0, 1'b0);
    waitDrain(100);

    $display("[TB] overflow admission");
    ready_fixed = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) applyStimulus(1016, 127, 1'b1, 1'b0, 1'b0);
    applyStimulus(1013, 127, 1'b1, 1'b0, 1'b0);
    checkOutput("level_508", 128'(fifo_level), 128'(508));
    applyStimulus(40, 5, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_over_capacity", 128'(drop_seen), 128'(1));
    checkOutput("level_after_drop", 128'(fifo_level), 128'(508));
    checkOutput("drop_strobes_silent", 128'(err_seen), 128'(2));
    applyStimulus(32, 4, 1'b1, 1'b0, 1'b0);
    checkOutput("level_full", 128'(fifo_level), 128'(512));
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_zero_len", 128'(drop_seen), 128'(2));
    ready_fixed = 1'b1;
    waitDrain(2000);

    $display("[TB] random backpressure");
    rand_ready_en = 1'b1;
    for (int p = 0; p < 50; p++) begin
      n = int'($urandom_range(1, 1600));
      applyStimulus(n, (n + 7) / 8, 1'b1, 1'b0, 1'b1);
      waitDrain(5000);
    end
    rand_ready_en = 1'b0;
    ready_fixed   = 1'b1;
    tick();
    tick();
    checkOutput("final_pulse_counts", 128'({32'(drop_seen), 32'(trunc_seen), 32'(err_seen)}),
                128'({32'd2, 32'd1, 32'd2}));
    checkOutput("final_level", 128'(fifo_level), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
